// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with forwarding, load-use bubble insertion and ALU operand steering
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_stall,
    input  logic            i_flush,
    input  logic            i_id_valid,
    input  logic [XLEN-1:0] i_id_pc,
    input  logic [XLEN-1:0] i_id_rs1_data,
    input  logic [XLEN-1:0] i_id_rs2_data,
    input  logic [XLEN-1:0] i_id_imm,
    input  logic [REGW-1:0] i_id_rs1,
    input  logic [REGW-1:0] i_id_rs2,
    input  logic [REGW-1:0] i_id_rd,
    input  logic [3:0]      i_id_alu_ctl,
    input  logic            i_id_alu_src_a,
    input  logic            i_id_alu_src_b,
    input  logic            i_id_reg_write,
    input  logic            i_id_mem_read,
    input  logic            i_id_mem_write,
    input  logic            i_id_mem_to_reg,
    input  logic            i_exm_reg_write,
    input  logic [REGW-1:0] i_exm_rd,
    input  logic [XLEN-1:0] i_exm_result,
    input  logic            i_wb_reg_write,
    input  logic [REGW-1:0] i_wb_rd,
    input  logic [XLEN-1:0] i_wb_data,
    output logic            o_load_use_hazard,
    output logic            o_ex_valid,
    output logic [XLEN-1:0] o_alu_a,
    output logic [XLEN-1:0] o_alu_b,
    output logic [3:0]      o_alu_ctl,
    output logic [XLEN-1:0] o_ex_store_data,
    output logic [XLEN-1:0] o_ex_pc,
    output logic [REGW-1:0] o_ex_rd,
    output logic            o_ex_reg_write,
    output logic            o_ex_mem_read,
    output logic            o_ex_mem_write,
    output logic            o_ex_mem_to_reg
);

    localparam logic [3:0] ALU_ADD = 4'd2;

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic [XLEN-1:0] r_imm;
    logic [REGW-1:0] r_rs1;
    logic [REGW-1:0] r_rs2;
    logic [REGW-1:0] r_rd;
    logic [3:0]      r_alu_ctl;
    logic            r_src_a;
    logic            r_src_b;
    logic            r_reg_write;
    logic            r_mem_read;
    logic            r_mem_write;
    logic            r_mem_to_reg;

    logic            w_load_use;
    logic            w_hold;
    logic            w_bubble;
    logic            w_wt1;
    logic            w_wt2;
    logic [XLEN-1:0] w_id_rs1_data;
    logic [XLEN-1:0] w_id_rs2_data;
    logic [XLEN-1:0] w_fwd1;
    logic [XLEN-1:0] w_fwd2;

    // EX/MEM has the younger value, so it is checked first; x0 is never forwarded.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [REGW-1:0] rs,
        input logic [XLEN-1:0] stored
    );
        if (i_exm_reg_write && (i_exm_rd != '0) && (i_exm_rd == rs))
            return i_exm_result;
        else if (i_wb_reg_write && (i_wb_rd != '0) && (i_wb_rd == rs))
            return i_wb_data;
        else
            return stored;
    endfunction

    // rs2 is compared even for immediate forms: a spurious bubble is cheaper than decode-aware logic.
    assign w_load_use = r_valid && r_mem_read && (r_rd != '0) && i_id_valid &&
                        ((r_rd == i_id_rs1) || (r_rd == i_id_rs2));

    assign w_hold   = i_stall && !i_flush;
    assign w_bubble = i_flush || w_load_use;

    // Register file is written and read in the same cycle; take the value being written.
    assign w_wt1 = i_wb_reg_write && (i_wb_rd != '0) && (i_wb_rd == i_id_rs1);
    assign w_wt2 = i_wb_reg_write && (i_wb_rd != '0) && (i_wb_rd == i_id_rs2);
    assign w_id_rs1_data = w_wt1 ? i_wb_data : i_id_rs1_data;
    assign w_id_rs2_data = w_wt2 ? i_wb_data : i_id_rs2_data;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid      <= 1'b0;
            r_pc         <= '0;
            r_rs1_data   <= '0;
            r_rs2_data   <= '0;
            r_imm        <= '0;
            r_rs1        <= '0;
            r_rs2        <= '0;
            r_rd         <= '0;
            r_alu_ctl    <= '0;
            r_src_a      <= 1'b0;
            r_src_b      <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
        end else if (!w_hold) begin
            if (w_bubble) begin
                r_valid      <= 1'b0;
                r_pc         <= '0;
                r_rs1_data   <= '0;
                r_rs2_data   <= '0;
                r_imm        <= '0;
                r_rs1        <= '0;
                r_rs2        <= '0;
                r_rd         <= '0;
                r_alu_ctl    <= ALU_ADD;
                r_src_a      <= 1'b0;
                r_src_b      <= 1'b0;
                r_reg_write  <= 1'b0;
                r_mem_read   <= 1'b0;
                r_mem_write  <= 1'b0;
                r_mem_to_reg <= 1'b0;
            end else begin
                r_valid      <= i_id_valid;
                r_pc         <= i_id_pc;
                r_rs1_data   <= w_id_rs1_data;
                r_rs2_data   <= w_id_rs2_data;
                r_imm        <= i_id_imm;
                r_rs1        <= i_id_rs1;
                r_rs2        <= i_id_rs2;
                r_rd         <= i_id_rd;
                r_alu_ctl    <= i_id_alu_ctl;
                r_src_a      <= i_id_alu_src_a;
                r_src_b      <= i_id_alu_src_b;
                r_reg_write  <= i_id_reg_write  && i_id_valid;
                r_mem_read   <= i_id_mem_read   && i_id_valid;
                r_mem_write  <= i_id_mem_write  && i_id_valid;
                r_mem_to_reg <= i_id_mem_to_reg && i_id_valid;
            end
        end
    end

    assign w_fwd1 = fwd_sel(r_rs1, r_rs1_data);
    assign w_fwd2 = fwd_sel(r_rs2, r_rs2_data);

    assign o_load_use_hazard = w_load_use;
    assign o_ex_valid        = r_valid;
    assign o_alu_a           = r_src_a ? r_pc  : w_fwd1;
    assign o_alu_b           = r_src_b ? r_imm : w_fwd2;
    assign o_ex_store_data   = w_fwd2;
    assign o_alu_ctl         = r_alu_ctl;
    assign o_ex_pc           = r_pc;
    assign o_ex_rd           = r_rd;
    assign o_ex_reg_write    = r_valid && r_reg_write;
    assign o_ex_mem_read     = r_valid && r_mem_read;
    assign o_ex_mem_write    = r_valid && r_mem_write;
    assign o_ex_mem_to_reg   = r_valid && r_mem_to_reg;

endmodule
